mem_io_responder: RTL and testbench

Memory-side responder for the CPU byte bus (`mem_a`, `mem_wr`, `mem_dout`, `mem_din`).
- Decodes each CPU access as either external synchronous RAM or memory-mapped I/O.
- Returns read data with the bus's fixed one-wait-cycle read timing.
- Implements the UART-style input/output ports, the free-running cycle counter and the program-stop flag.
- Sits between the CPU top and the RAM/UART blocks, and drives the CPU `rdy_in` back-pressure.

---
 rtl/mem_io_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Brief    : CPU byte-bus responder: RAM/IO decode, one-wait-cycle reads,
//            RX/TX ports, cycle counter with coherent snapshot, halt flag.
// Revision : 1.0  initial release
// ============================================================================
module mem_io_responder #(
    parameter int RAM_AW    = 17,
    parameter int TXQ_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [31:0]       mem_a,
    input  logic              mem_wr,
    input  logic [7:0]        mem_dout,
    output logic [7:0]        mem_din,
    output logic              rdy_out,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              halt,
    output logic              tx_ovf
);

    localparam int c_ptr_w = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(TXQ_DEPTH);
    localparam logic [c_cnt_w-1:0] c_depth_m2 = c_cnt_w'(TXQ_DEPTH - 2);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_is_io;
    logic       w_is_ram;
    logic       w_io_rd;
    logic       w_io_wr;
    logic [2:0] w_off;
    logic       w_unused_addr;

    assign w_is_io       = (mem_a[17:16] == 2'b11);
    assign w_is_ram      = ~mem_a[17];
    assign w_io_rd       = w_is_io & ~mem_wr;
    assign w_io_wr       = w_is_io & mem_wr;
    assign w_off         = mem_a[2:0];
    assign w_unused_addr = ^mem_a[31:18];

    // ------------------------------------------------------------------
    // Cycle counter and snapshot
    // ------------------------------------------------------------------
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_snap;
    logic        w_snap_ld;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cycle_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_snap <= 32'd0;
        end else if (w_snap_ld) begin
            r_snap <= r_cycle_cnt;
        end
    end

    // ------------------------------------------------------------------
    // I/O read data and side-effect strobes
    // ------------------------------------------------------------------
    logic [7:0] w_io_rdata;
    logic       w_rx_pop;

    always_comb begin
        w_io_rdata = 8'h00;
        w_rx_pop   = 1'b0;
        w_snap_ld  = 1'b0;
        if (w_io_rd) begin
            case (w_off)
                3'd0: begin
                    if (rx_valid) begin
                        w_io_rdata = rx_data;
                        w_rx_pop   = 1'b1;
                    end
                end
                3'd4: begin
                    w_io_rdata = r_cycle_cnt[7:0];
                    w_snap_ld  = 1'b1;
                end
                3'd5:    w_io_rdata = r_snap[15:8];
                3'd6:    w_io_rdata = r_snap[23:16];
                3'd7:    w_io_rdata = r_snap[31:24];
                default: w_io_rdata = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read response. A RAM read shows ram_rdata directly during the
    // response cycle and is folded into r_hold on the following edge, so
    // mem_din keeps that byte while later writes move ram_a.
    // ------------------------------------------------------------------
    logic       r_rd_ram;
    logic [7:0] r_hold;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_ram <= 1'b0;
            r_hold   <= 8'h00;
        end else begin
            if (r_rd_ram) begin
                r_hold <= ram_rdata;
            end
            if (!mem_wr) begin
                r_rd_ram <= w_is_ram;
                if (!w_is_ram) begin
                    r_hold <= w_io_rdata;
                end
            end else begin
                r_rd_ram <= 1'b0;
            end
        end
    end

    assign mem_din = r_rd_ram ? ram_rdata : r_hold;

    // ------------------------------------------------------------------
    // RAM port and RX strobe, held inactive while reset is asserted
    // ------------------------------------------------------------------
    assign ram_a     = rst_in ? mem_a[RAM_AW-1:0] : '0;
    assign ram_wdata = rst_in ? mem_dout : 8'h00;
    assign ram_we    = rst_in & w_is_ram & mem_wr;
    assign rx_ready  = rst_in & w_rx_pop;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_txq [TXQ_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic [7:0]         w_push_data;
    logic               w_pop;
    logic               w_full;
    logic               w_accept;

    assign w_push      = w_io_wr & (((w_off == 3'd0) & (mem_dout != 8'h00)) |
                                    (w_off == 3'd4));
    assign w_push_data = (w_off == 3'd4) ? 8'h00 : mem_dout;
    assign w_pop       = (r_count != '0) & tx_ready;
    assign w_full      = (r_count == c_depth);
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_accept    = w_push & (~w_full | w_pop);

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_txq[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign tx_valid = (r_count != '0);
    assign tx_data  = tx_valid ? r_txq[r_rd_ptr] : 8'h00;
    assign rdy_out  = (r_count <= c_depth_m2);

    // ------------------------------------------------------------------
    // Sticky flags
    // ------------------------------------------------------------------
    logic r_halt;
    logic r_tx_ovf;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_halt   <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_io_wr && (w_off == 3'd4)) begin
                r_halt <= 1'b1;
            end
            if (w_push && !w_accept) begin
                r_tx_ovf <= 1'b1;
            end
        end
    end

    assign halt   = r_halt;
    assign tx_ovf = r_tx_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_responder
// Brief    : Directed bench for mem_io_responder with a read-data scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        rdy_out;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic        tx_ovf;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  sb_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  ram_mem [0:(1<<17)-1];
    logic [31:0] tb_cnt;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(.RAM_AW(17), .TXQ_DEPTH(8)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .rdy_out   (rdy_out),
        .ram_a     (ram_a),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .tx_ovf    (tx_ovf)
    );

    // Synchronous RAM: data for ram_a appears after the next edge
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_wdata;
        ram_rdata <= ram_mem[ram_a];
    end

    // Reference cycle count: cleared by reset, +1 every edge
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) tb_cnt <= 32'd0;
        else         tb_cnt <= tb_cnt + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: check the previous read's response, then drive the next access
    task automatic access(input logic [31:0] a, input logic wr, input logic [7:0] d,
                          input logic [7:0] exp);
        logic [7:0] e;
        @(negedge clk_in);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("mem_din", {24'd0, mem_din}, {24'd0, e});
        end
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        if (!wr) sb_q.push_back(exp);
    endtask

    task automatic idle();
        access(32'h0002_0000, 1'b1, 8'h00, 8'h00);
    endtask

    initial begin
        int guard;
        rst_in   = 1'b0;
        mem_a    = 32'h0000_0123;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        #12;
        chk("rst_mem_din",   {24'd0, mem_din}, 32'h0);
        chk("rst_rdy_out",   {31'd0, rdy_out}, 32'h1);
        chk("rst_ram_a",     {15'd0, ram_a},   32'h0);
        chk("rst_tx_valid",  {31'd0, tx_valid}, 32'h0);
        chk("rst_halt",      {31'd0, halt},    32'h0);
        mem_a  = 32'h0002_0000;
        mem_wr = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;

        // RAM write then read back
        access(32'h0000_0123, 1'b1, 8'hA5, 8'h00);
        #1;
        chk("ram_we_wr",    {31'd0, ram_we}, 32'h1);
        chk("ram_a_wr",     {15'd0, ram_a},  32'h123);
        chk("ram_wdata_wr", {24'd0, ram_wdata}, 32'hA5);
        access(32'h0000_0123, 1'b0, 8'h00, 8'hA5);
        #1;
        chk("ram_we_rd", {31'd0, ram_we}, 32'h0);
        access(32'h0002_5000, 1'b0, 8'h00, 8'h00);
        #1;
        chk("ram_we_unmapped", {31'd0, ram_we}, 32'h0);
        access(32'h0000_0123, 1'b0, 8'h00, 8'hA5);
        access(32'h0000_0200, 1'b1, 8'h5A, 8'h00);
        idle();
        #1;
        chk("mem_din_hold", {24'd0, mem_din}, 32'hA5);

        // Input port
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        access(32'h0003_0000, 1'b0, 8'h00, 8'h41);
        #1;
        chk("rx_ready_pop", {31'd0, rx_ready}, 32'h1);
        idle();
        #1;
        chk("rx_ready_idle", {31'd0, rx_ready}, 32'h0);
        rx_valid = 1'b0;
        access(32'h0003_0000, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rx_ready_empty", {31'd0, rx_ready}, 32'h0);
        access(32'h0003_0001, 1'b0, 8'h00, 8'h00);

        // Counter coherence at 0x1FF
        guard = 0;
        do begin
            idle();
            guard++;
        end while (tb_cnt != 32'h1FE && guard < 2000);
        chk("cnt_reach", {31'd0, guard < 2000}, 32'h1);
        access(32'h0003_0004, 1'b0, 8'h00, tb_cnt[7:0] + 8'd1);
        access(32'h0003_0005, 1'b0, 8'h00, 8'h01);
        access(32'h0003_0006, 1'b0, 8'h00, 8'h00);
        access(32'h0003_0007, 1'b0, 8'h00, 8'h00);
        idle();

        // Counter wrap
        access(32'h0003_0004, 1'b0, 8'h00, 8'hFF);
        force dut.r_cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle_cnt;
        access(32'h0003_0004, 1'b0, 8'h00, 8'h00);
        access(32'h0003_0007, 1'b0, 8'h00, 8'h00);
        access(32'h0003_0006, 1'b0, 8'h00, 8'h00);
        idle();

        // TX back-pressure and overflow
        for (int i = 1; i <= 9; i++) begin
            access(32'h0003_0000, 1'b1, 8'h30 + 8'(i), 8'h00);
            #1;
            chk("rdy_out_fill", {31'd0, rdy_out}, {31'd0, (((i - 1) > 8 ? 8 : (i - 1)) <= 6)});
            chk("tx_ovf_fill",  {31'd0, tx_ovf}, 32'h0);
            if (i <= 8) tx_q.push_back(8'h30 + 8'(i));
        end
        idle();
        #1;
        chk("tx_ovf_set",  {31'd0, tx_ovf},  32'h1);
        chk("rdy_out_full", {31'd0, rdy_out}, 32'h0);
        tx_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("tx_valid_drain", {31'd0, tx_valid}, 32'h1);
            chk("tx_data_drain",  {24'd0, tx_data},  {24'd0, tx_q.pop_front()});
            idle();
            #1;
        end
        chk("tx_valid_empty", {31'd0, tx_valid}, 32'h0);
        chk("rdy_out_empty",  {31'd0, rdy_out},  32'h1);

        // Zero filter and halt
        tx_ready = 1'b0;
        access(32'h0003_0000, 1'b1, 8'h00, 8'h00);
        idle();
        #1;
        chk("zero_filter", {31'd0, tx_valid}, 32'h0);
        chk("halt_clear",  {31'd0, halt},     32'h0);
        access(32'h0003_0004, 1'b1, 8'h77, 8'h00);
        idle();
        #1;
        chk("halt_set",      {31'd0, halt},     32'h1);
        chk("halt_tx_valid", {31'd0, tx_valid}, 32'h1);
        chk("halt_tx_data",  {24'd0, tx_data},  32'h0);
        chk("tx_ovf_sticky", {31'd0, tx_ovf},   32'h1);
        access(32'h0000_0300, 1'b1, 8'h3C, 8'h00);
        access(32'h0000_0300, 1'b0, 8'h00, 8'h3C);
        idle();

        // Async reset during a pending read
        access(32'h0000_0123, 1'b0, 8'h00, 8'hA5);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        sb_q.delete();
        chk("arst_mem_din",   {24'd0, mem_din},   32'h0);
        chk("arst_rdy_out",   {31'd0, rdy_out},   32'h1);
        chk("arst_ram_a",     {15'd0, ram_a},     32'h0);
        chk("arst_ram_we",    {31'd0, ram_we},    32'h0);
        chk("arst_tx_valid",  {31'd0, tx_valid},  32'h0);
        chk("arst_tx_data",   {24'd0, tx_data},   32'h0);
        chk("arst_halt",      {31'd0, halt},      32'h0);
        chk("arst_tx_ovf",    {31'd0, tx_ovf},    32'h0);
        mem_a  = 32'h0002_0000;
        mem_wr = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        idle();
        idle();
        #1;
        chk("post_rst_mem_din",  {24'd0, mem_din},  32'h0);
        chk("post_rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
